conv_weight_loader: RTL



---
 rtl/conv_pkg.sv | 23 ++
 rtl/conv_weight_loader_if.sv | 17 +
 rtl/weight_sync_fifo.sv | 56 +++++
 rtl/conv_weight_loader.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, tap extraction helper and sequencer state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_pkg;

  localparam int KERNEL_TAPS = 9;
  localparam int TAP_WIDTH   = 16;
  localparam int WORD_WIDTH  = KERNEL_TAPS * TAP_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fsm_state_e;

  // Tap idx of a packed 3x3 kernel word; tap 0 is top-left, row-major order.
  function automatic logic signed [TAP_WIDTH-1:0] get_tap(input logic [WORD_WIDTH-1:0] word,
                                                          input int idx);
    return word[idx*TAP_WIDTH +: TAP_WIDTH];
  endfunction

endpackage

// File: rtl/conv_weight_loader_if.sv
// conv_weight_loader_if: kernel beat stream from the weight loader to the MAC array.
// Latency: n/a (wires only).
// Backpressure: consumer drives k_ready; producer holds the beat stable while stalled.
// Signals: k_valid/k_ready handshake, k_data (nine taps), k_index (ordinal), k_last.
interface conv_weight_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 144
);
  logic                  k_valid;
  logic                  k_ready;
  logic [DATA_WIDTH-1:0] k_data;
  logic [ADDR_WIDTH-1:0] k_index;
  logic                  k_last;

  modport master (output k_valid, output k_data, output k_index, output k_last, input k_ready);
  modport slave  (input k_valid, input k_data, input k_index, input k_last, output k_ready);
endinterface

// File: rtl/weight_sync_fifo.sv
// weight_sync_fifo: synchronous FIFO with occupancy count; head is the registered oldest entry.
// Latency: push to head visible 1 cycle; pop and push may occur in the same cycle.
// Backpressure: none internally; the writer must never push when full (credit-gated upstream).
// Ports: clk, rst (async, active-high), push_i/push_dat_i, pop_i, head_o, count_o, empty_o.
module weight_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/conv_weight_loader.sv
// conv_weight_loader: walks a ROM word range, unpacks nine taps per word, streams one kernel per beat.
// Latency: start to first k_valid = 2 + RD_LATENCY cycles; 1 kernel/cycle sustained.
// Backpressure: full valid/ready; ROM reads are credit-gated against the output FIFO.
// Ports: clk, tb_rst (async, active-high), start/base_addr/num_kernels command, busy/done status,
//        rom_addr/rom_rd_data ROM side, k (kernel stream master).
// Optional: CONV_WEIGHT_LOADER_CHECKSUM_EN adds a 16-bit wrapping checksum of transferred taps.
module conv_weight_loader
  import conv_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 144,
  parameter int WEIGHT_WIDTH = 16,
  parameter int RD_LATENCY   = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_kernels,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  conv_weight_loader_if.master  k
`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
  ,
  output logic [WEIGHT_WIDTH-1:0] checksum
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  fsm_state_e            state_q;
  logic [ADDR_WIDTH-1:0] base_q, rom_addr_q;
  logic [ADDR_WIDTH:0]   total_q, issued_q, pushed_q;
  logic                  busy_q, done_q;
  // tag_q[0] is set on the edge the address registers; data is valid while tag_q[RD_LATENCY] is set.
  logic [RD_LATENCY:0]   tag_q;

  logic                  start_ok, issue, issue_last, credit_ok, drained;
  logic [ADDR_WIDTH-1:0] issue_addr;
  int unsigned           inflight;
  logic                  push, pop, push_last, fifo_empty;
  logic [ADDR_WIDTH-1:0] push_idx;
  logic [DATA_WIDTH-1:0] taps;
  logic [ENT_W-1:0]      head;
  logic [CNT_W-1:0]      fifo_count;

  always_comb begin
    inflight = 0;
    for (int i = 0; i <= RD_LATENCY; i++) inflight = inflight + 32'(tag_q[i]);
  end

  assign credit_ok = (32'(fifo_count) + inflight) < 32'(FIFO_DEPTH);

  // The first read issues on the same edge that accepts the command, which is what
  // keeps start-to-valid at 2 + RD_LATENCY.
  always_comb begin
    start_ok   = (state_q == IDLE) && start;
    issue      = 1'b0;
    issue_addr = base_q + issued_q[ADDR_WIDTH-1:0];
    issue_last = ((issued_q + (ADDR_WIDTH+1)'(1)) == total_q);
    if (start_ok) begin
      issue      = (num_kernels != '0);
      issue_addr = base_addr;
      issue_last = (num_kernels == (ADDR_WIDTH+1)'(1));
    end else if (state_q == FETCH) begin
      issue = credit_ok;
    end
  end

  // Returned words arrive in issue order, so a running push count is the kernel ordinal.
  assign push      = tag_q[RD_LATENCY];
  assign push_idx  = pushed_q[ADDR_WIDTH-1:0];
  assign push_last = ((pushed_q + (ADDR_WIDTH+1)'(1)) == total_q);

  always_comb begin
    taps = '0;
    for (int i = 0; i < KERNEL_TAPS; i++) taps[i*TAP_WIDTH +: TAP_WIDTH] = get_tap(rom_rd_data, i);
  end

  assign pop = !fifo_empty && k.k_ready;

  // Leaving DRAIN on the cycle of the final pop makes done land right after the last beat.
  assign drained = (tag_q == '0) &&
                   ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));

  weight_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (tb_rst),
    .push_i     (push),
    .push_dat_i ({push_last, push_idx, taps}),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (fifo_count),
    .empty_o    (fifo_empty)
  );

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      total_q    <= '0;
      issued_q   <= '0;
      pushed_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rom_addr_q <= '0;
      tag_q      <= '0;
    end else begin
      tag_q  <= {tag_q[RD_LATENCY-1:0], issue};
      done_q <= 1'b0;
      if (push) pushed_q <= pushed_q + (ADDR_WIDTH+1)'(1);
      if (issue) begin
        rom_addr_q <= issue_addr;
        issued_q   <= issued_q + (ADDR_WIDTH+1)'(1);
      end
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            base_q   <= base_addr;
            total_q  <= num_kernels;
            pushed_q <= '0;
            if (num_kernels == '0) begin
              issued_q <= '0;
              state_q  <= DONE;
              done_q   <= 1'b1;
            end else begin
              issued_q <= (ADDR_WIDTH+1)'(1);
              busy_q   <= 1'b1;
              state_q  <= issue_last ? DRAIN : FETCH;
            end
          end
        end
        FETCH: begin
          if (issue && issue_last) state_q <= DRAIN;
        end
        DRAIN: begin
          if (drained) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rom_addr  = rom_addr_q;
  assign k.k_valid = !fifo_empty;
  assign k.k_last  = head[ENT_W-1];
  assign k.k_index = head[DATA_WIDTH +: ADDR_WIDTH];
  assign k.k_data  = head[DATA_WIDTH-1:0];

`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
  logic [WEIGHT_WIDTH-1:0] csum_q, beat_sum;

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < KERNEL_TAPS; i++) beat_sum = beat_sum + unsigned'(get_tap(k.k_data, i));
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst)        csum_q <= '0;
    else if (start_ok) csum_q <= '0;
    else if (pop)      csum_q <= csum_q + beat_sum;
  end

  assign checksum = csum_q;
`endif

endmodule
